// File: rtl/uart_comm_pkg.sv
// Shared state encoding and framing constants for the host UART command link.
package uart_comm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int DATA_BITS = 8;
  localparam int CMD_BYTES = 3;

endpackage

// File: rtl/uart_tx.sv
// 8N1 serializer: one start bit, eight data bits LSB first, one stop bit.
module uart_tx
  import uart_comm_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       trmt,
  output logic       TX,
  output logic       tx_done
);

  localparam int            BW        = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BAUD_PRE  = BW'(BAUD_DIV - 2);

  uart_state_t   r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          r_done;

  // Transmit FSM; tx_done is raised one clock early so it lands on the last stop-bit clock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (trmt) begin
            r_shift <= tx_data;
            r_tx    <= 1'b0;
            r_baud  <= '0;
            r_state <= START;
          end
        end
        START: begin
          if (r_baud == BAUD_LAST) begin
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_tx    <= r_shift[0];
            r_state <= DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        DATA: begin
          if (r_baud == BAUD_LAST) begin
            r_baud <= '0;
            if (r_bit == 3'(DATA_BITS - 1)) begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        STOP: begin
          if (r_baud == BAUD_PRE) begin
            r_done <= 1'b1;
          end
          if (r_baud == BAUD_LAST) begin
            r_baud  <= '0;
            r_state <= IDLE;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign TX      = r_tx;
  assign tx_done = r_done;

endmodule

// File: rtl/uart_cmd_comm.sv
// Host serial front end: receives 3-byte commands with a ready/clear handshake
// and transmits single response bytes through uart_tx.
module uart_cmd_comm
  import uart_comm_pkg::*;
#(
  parameter int BAUD_DIV      = 2604,
  parameter int FRAME_TO_BITS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp_data,
  input  logic        send_resp,
  output logic        resp_sent
);

  localparam int            BW        = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);
  localparam int            TO_CLKS   = FRAME_TO_BITS * BAUD_DIV;
  localparam int            TW        = $clog2(TO_CLKS + 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TO_CLKS - 1);
  localparam logic [TW-1:0] TO_MAX    = TW'(TO_CLKS);

  logic          r_rx_meta, r_rx_sync, r_rx_prev;
  uart_state_t   r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_rx_done, r_rx_ferr;
  logic [1:0]    r_byte_cnt;
  logic [TW-1:0] r_idle_cnt;
  logic [23:0]   r_cmd;
  logic          r_cmd_rdy;
  logic          w_start, w_timeout;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= RX;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_start   = (r_state == IDLE) && r_rx_prev && !r_rx_sync;
  assign w_timeout = (r_state == IDLE) && (r_byte_cnt != 2'd0) && (r_idle_cnt == TO_LAST);

  // Receive FSM; rx_done / rx_ferr pulse the clock after the stop-bit sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_baud    <= '0;
      r_bit     <= 3'd0;
      r_shift   <= 8'd0;
      r_rx_done <= 1'b0;
      r_rx_ferr <= 1'b0;
    end else begin
      r_rx_done <= 1'b0;
      r_rx_ferr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_baud  <= '0;
            r_state <= START;
          end
        end
        START: begin
          if (r_baud == HALF_LAST) begin
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_state <= r_rx_sync ? IDLE : DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        DATA: begin
          if (r_baud == BAUD_LAST) begin
            r_baud  <= '0;
            r_shift <= {r_rx_sync, r_shift[7:1]};
            if (r_bit == 3'(DATA_BITS - 1)) begin
              r_state <= STOP;
            end else begin
              r_bit <= r_bit + 3'd1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        STOP: begin
          if (r_baud == BAUD_LAST) begin
            r_baud    <= '0;
            r_state   <= IDLE;
            r_rx_done <= r_rx_sync;
            r_rx_ferr <= !r_rx_sync;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Command packing, inter-byte timeout and the ready handshake (set beats clear).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_byte_cnt <= 2'd0;
      r_idle_cnt <= '0;
      r_cmd      <= 24'd0;
      r_cmd_rdy  <= 1'b0;
    end else begin
      if (w_start) begin
        r_idle_cnt <= '0;
      end else if ((r_state == IDLE) && (r_byte_cnt != 2'd0) && (r_idle_cnt != TO_MAX)) begin
        r_idle_cnt <= r_idle_cnt + 1'b1;
      end

      if (r_rx_ferr || w_timeout) begin
        r_byte_cnt <= 2'd0;
      end else if (r_rx_done) begin
        if (r_cmd_rdy) begin
          r_byte_cnt <= 2'd0;
        end else begin
          case (r_byte_cnt)
            2'd0:    r_cmd[23:16] <= r_shift;
            2'd1:    r_cmd[15:8]  <= r_shift;
            default: r_cmd[7:0]   <= r_shift;
          endcase
          r_byte_cnt <= (r_byte_cnt == 2'(CMD_BYTES - 1)) ? 2'd0 : r_byte_cnt + 2'd1;
        end
      end

      if (r_rx_done && !r_rx_ferr && !r_cmd_rdy && (r_byte_cnt == 2'(CMD_BYTES - 1))) begin
        r_cmd_rdy <= 1'b1;
      end else if (clr_cmd_rdy) begin
        r_cmd_rdy <= 1'b0;
      end
    end
  end

  assign cmd     = r_cmd;
  assign cmd_rdy = r_cmd_rdy;

  uart_tx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .tx_data(resp_data),
    .trmt   (send_resp),
    .TX     (TX),
    .tx_done(resp_sent)
  );

endmodule

// File: tb/tb_uart_cmd_comm.sv
// Self-checking bench for uart_cmd_comm: frame-level reference model plus directed and random traffic.
module tb_uart_cmd_comm;

  localparam int BD      = 16;
  localparam int FTB     = 4;
  localparam int TO_CLKS = BD * FTB;
  localparam int FRAME   = 10 * BD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic [7:0]  resp_data = 8'd0;
  logic        TX, cmd_rdy, resp_sent;
  logic [23:0] cmd;

  int total = 0;
  int bad   = 0;

  uart_cmd_comm #(.BAUD_DIV(BD), .FRAME_TO_BITS(FTB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RX         (RX),
    .TX         (TX),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .resp_data  (resp_data),
    .send_resp  (send_resp),
    .resp_sent  (resp_sent)
  );

  always #5 clk = ~clk;

  // Reference model state
  int          cyc = 0;
  int          c0 = 0;
  bit          tx_active = 1'b0;
  logic [7:0]  tx_byte = 8'd0;
  logic [23:0] m_cmd = 24'd0;
  bit          m_rdy = 1'b0;
  int          m_cnt = 0;
  int          last_end = 0;
  bit          rx_quiet = 1'b1;
  bit          chk_en = 1'b0;
  int          n_sent = 0;

  function automatic logic frame_bit(input logic [7:0] d, input int i);
    if (i == 0) return 1'b0;
    else if (i >= 9) return 1'b1;
    else return d[i-1];
  endfunction

  task automatic chk_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_word(input string name, input logic [23:0] act, input logic [23:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transmit model: which frame is on the wire, and when the next request may be taken
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) tx_active = 1'b0;
    else if (send_resp && (!tx_active || cyc >= c0 + FRAME + 1)) begin
      c0        = cyc;
      tx_byte   = resp_data;
      tx_active = 1'b1;
    end
  end

  always @(negedge clk) if (resp_sent) n_sent++;

  // Per-cycle comparison against the model
  always @(negedge clk) begin : compare
    int   k;
    logic etx, esent;
    #2;
    if (chk_en) begin
      k = cyc - c0;
      if (tx_active && k < FRAME) begin
        etx   = frame_bit(tx_byte, k / BD);
        esent = (k == FRAME - 1);
      end else begin
        etx   = 1'b1;
        esent = 1'b0;
      end
      chk_bit("tx_line", TX, etx);
      chk_bit("resp_sent", resp_sent, esent);
      if (rx_quiet) begin
        chk_word("cmd", cmd, m_cmd);
        chk_bit("cmd_rdy", cmd_rdy, m_rdy);
      end
    end
  end

  function automatic void model_byte(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok || m_rdy) m_cnt = 0;
    else begin
      m_cmd[23 - 8*m_cnt -: 8] = b;
      if (m_cnt == 2) begin
        m_rdy = 1'b1;
        m_cnt = 0;
      end else m_cnt++;
    end
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Drive one frame (or its first nclk clocks); full frames update the model afterwards
  task automatic rx_frame(input logic [7:0] b, input bit stop_ok, input int nclk);
    if (m_cnt != 0 && (cyc - last_end) + BD/2 >= TO_CLKS) m_cnt = 0;
    rx_quiet = 1'b0;
    for (int i = 0; i < FRAME && i < nclk; i++) begin
      RX = (i / BD == 9) ? stop_ok : frame_bit(b, i / BD);
      @(negedge clk);
    end
    RX = 1'b1;
    if (nclk >= FRAME) begin
      if (!stop_ok) idle(BD);
      model_byte(b, stop_ok);
      last_end = cyc;
      rx_quiet = 1'b1;
    end
  endtask

  task automatic send_cmd(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    rx_frame(b0, 1'b1, FRAME);
    rx_frame(b1, 1'b1, FRAME);
    rx_frame(b2, 1'b1, FRAME);
    idle(4);
  endtask

  task automatic clear_rdy();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    m_rdy = 1'b0;
  endtask

  task automatic tx_send(input logic [7:0] d, output int acc);
    acc       = cyc + 1;
    resp_data = d;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    RX          = 1'b1;
    clr_cmd_rdy = 1'b0;
    send_resp   = 1'b0;
    @(negedge clk);
    chk_bit("rst_tx", TX, 1'b1);
    chk_word("rst_cmd", cmd, 24'h000000);
    chk_bit("rst_cmd_rdy", cmd_rdy, 1'b0);
    chk_bit("rst_resp_sent", resp_sent, 1'b0);
    m_cmd    = 24'd0;
    m_rdy    = 1'b0;
    m_cnt    = 0;
    last_end = cyc;
    rx_quiet = 1'b1;
    rst_n    = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin : stim
    int acc, acc2, n0;
    repeat (3) @(negedge clk);
    do_reset();
    chk_en = 1'b1;
    idle(10);

    // 1: basic command and handshake
    send_cmd(8'hA5, 8'h01, 8'h3C);
    chk_word("t1_cmd", cmd, 24'hA5013C);
    chk_bit("t1_rdy", cmd_rdy, 1'b1);
    idle(20);
    chk_bit("t1_rdy_held", cmd_rdy, 1'b1);
    clear_rdy();
    chk_bit("t1_rdy_cleared", cmd_rdy, 1'b0);
    idle(10);

    // 2: inter-byte timeout drops a lone byte
    rx_frame(8'h12, 1'b1, FRAME);
    idle(5 * BD);
    send_cmd(8'h34, 8'h56, 8'h78);
    chk_word("t2_cmd", cmd, 24'h345678);
    clear_rdy();
    idle(10);

    // 3: overrun while ready is pending
    send_cmd(8'h11, 8'h22, 8'h33);
    send_cmd(8'hFF, 8'hEE, 8'hDD);
    chk_word("t3_cmd_held", cmd, 24'h112233);
    chk_bit("t3_rdy_held", cmd_rdy, 1'b1);
    clear_rdy();
    send_cmd(8'h44, 8'h55, 8'h66);
    chk_word("t3_cmd_new", cmd, 24'h445566);
    clear_rdy();
    idle(10);

    // 4: framing error, then a short glitch
    rx_frame(8'h99, 1'b0, FRAME);
    send_cmd(8'h0A, 8'h0B, 8'h0C);
    chk_word("t4_cmd", cmd, 24'h0A0B0C);
    clear_rdy();
    RX = 1'b0;
    idle(4);
    RX = 1'b1;
    idle(40);
    chk_bit("t4_glitch_rdy", cmd_rdy, 1'b0);
    send_cmd(8'hC1, 8'hC2, 8'hC3);
    chk_word("t4_after_glitch", cmd, 24'hC1C2C3);
    clear_rdy();
    idle(10);

    // 5: transmit 0x5A, ignored mid-frame request, back-to-back boundary
    n0 = n_sent;
    tx_send(8'h5A, acc);
    wait_cyc(acc + 8);
    chk_bit("t5_start_bit", TX, 1'b0);
    wait_cyc(acc + 40);
    chk_bit("t5_bit1", TX, 1'b1);
    wait_cyc(acc + 79);
    resp_data = 8'hFF;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    chk_bit("t5_bit4", TX, 1'b1);
    wait_cyc(acc + 100);
    chk_bit("t5_bit5_not_ff", TX, 1'b0);
    wait_cyc(acc + 159);
    chk_bit("t5_sent_pulse", resp_sent, 1'b1);
    resp_data = 8'hC3;
    send_resp = 1'b1;
    @(negedge clk);
    chk_bit("t5_sent_over", resp_sent, 1'b0);
    chk_bit("t5_gap_high", TX, 1'b1);
    @(negedge clk);
    send_resp = 1'b0;
    acc2 = acc + FRAME + 1;
    wait_cyc(acc2 + 8);
    chk_bit("t5_b2b_start", TX, 1'b0);
    wait_cyc(acc2 + 24);
    chk_bit("t5_b2b_bit0", TX, 1'b1);
    wait_cyc(acc2 + 56);
    chk_bit("t5_b2b_bit2", TX, 1'b0);
    wait_cyc(acc2 + FRAME + 5);
    chk_word("t5_pulse_count", 24'(n_sent - n0), 24'd2);

    // 6: reset mid-TX and mid-RX, then a clean command
    tx_send(8'h81, acc);
    wait_cyc(acc + 50);
    do_reset();
    idle(10);
    rx_frame(8'hB7, 1'b1, FRAME);
    chk_word("t6_partial", cmd, 24'hB70000);
    rx_frame(8'h6D, 1'b1, 70);
    do_reset();
    idle(20);
    send_cmd(8'hDE, 8'hAD, 8'h42);
    chk_word("t6_cmd", cmd, 24'hDEAD42);
    clear_rdy();
    idle(10);

    // Random traffic on both directions
    fork
      begin : rnd_tx
        int a;
        for (int n = 0; n < 12; n++) begin
          tx_send(8'($urandom), a);
          if ($urandom_range(0, 1) == 1) begin
            wait_cyc(a + $urandom_range(1, 150));
            resp_data = 8'($urandom);
            send_resp = 1'b1;
            @(negedge clk);
            send_resp = 1'b0;
          end
          wait_cyc(a + FRAME + $urandom_range(0, 3));
        end
      end
      begin : rnd_rx
        for (int n = 0; n < 8; n++) begin
          for (int b = 0; b < 3; b++) begin
            idle(($urandom_range(0, 1) == 1) ? $urandom_range(0, 16) : $urandom_range(80, 120));
            rx_frame(8'($urandom), ($urandom_range(0, 9) != 0), FRAME);
          end
          idle(4);
          if (m_rdy && $urandom_range(0, 3) != 0) clear_rdy();
        end
      end
    join
    idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
